// File: rtl/qpu_ifu_ift2itcm_pkg.sv
// Shared definitions for the IFU fetch-to-ITCM controller: FSM encoding and default constants.
package qpu_ifu_ift2itcm_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [31:0] ITCM_BASE_DEF = 32'h8000_0000;
  localparam logic [31:0] ERR_INSTR_DEF = 32'h0000_0013;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/qpu_ift_rsp_buf.sv
// One-entry skid buffer for a fetch response {err, instr}; data reloads whenever load is set,
// the valid bit marks a response that is waiting for the IFU.
module qpu_ift_rsp_buf #(
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               set_vld,
  input  logic               clr_vld,
  input  logic               din_err,
  input  logic [INSTR_W-1:0] din_instr,
  output logic               vld,
  output logic               err,
  output logic [INSTR_W-1:0] instr
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld   <= 1'b0;
      err   <= 1'b0;
      instr <= '0;
    end else begin
      if (load) begin
        err   <= din_err;
        instr <= din_instr;
      end
      if (set_vld)      vld <= 1'b1;
      else if (clr_vld) vld <= 1'b0;
    end
  end

endmodule

// File: rtl/qpu_ifu_ift2itcm.sv
// IFU ifetch REQ/RSP terminator reading a 1-cycle-latency ITCM, one transaction outstanding.
// Optional macro QPU_IFT2ITCM_SEQ_REUSE_EN adds a one-entry last-fetch cache for sequential hints.
module qpu_ifu_ift2itcm
  import qpu_ifu_ift2itcm_pkg::*;
#(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter int                 ITCM_AW   = 12,
  parameter logic [PC_W-1:0]    ITCM_BASE = PC_W'(ITCM_BASE_DEF),
  parameter logic [INSTR_W-1:0] ERR_INSTR = INSTR_W'(ERR_INSTR_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ifu_req_valid,
  output logic               ifu_req_ready,
  input  logic [PC_W-1:0]    ifu_req_pc,
  input  logic               ifu_req_seq,
  output logic               ifu_rsp_valid,
  input  logic               ifu_rsp_ready,
  output logic [INSTR_W-1:0] ifu_rsp_instr,
  output logic               ifu_rsp_err,
  output logic               itcm_cs,
  output logic [ITCM_AW-1:0] itcm_addr,
  input  logic [INSTR_W-1:0] itcm_rdata
);

  logic [1:0]         state_q, state_d;
  logic               hit, req_fire, rsp_fire;
  logic               err_p1;
  logic [INSTR_W-1:0] rd_data, rd_instr;
  logic               buf_vld, buf_err;
  logic [INSTR_W-1:0] buf_instr;

  assign hit = is_word_aligned(ifu_req_pc[1:0]) &&
               (ifu_req_pc[PC_W-1:ITCM_AW+2] == ITCM_BASE[PC_W-1:ITCM_AW+2]);
  assign itcm_addr = ifu_req_pc[ITCM_AW+1:2];

  assign ifu_rsp_valid = (state_q == ST_RD) | buf_vld;
  assign rsp_fire      = ifu_rsp_valid & ifu_rsp_ready;
  assign ifu_req_ready = (state_q == ST_IDLE) | rsp_fire;
  assign req_fire      = ifu_req_valid & ifu_req_ready;

`ifdef QPU_IFT2ITCM_SEQ_REUSE_EN
  logic [ITCM_AW-1:0] cache_addr_q;
  logic [INSTR_W-1:0] cache_data_q;
  logic               cache_vld_q, cache_hit, from_cache_p1;

  assign cache_hit = ifu_req_seq & cache_vld_q & (cache_addr_q == itcm_addr);
  assign itcm_cs   = req_fire & hit & ~cache_hit;
  assign rd_data   = from_cache_p1 ? cache_data_q : itcm_rdata;

  // Tag/valid follow the read issue; data lands one cycle later with the SRAM output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cache_vld_q   <= 1'b0;
      from_cache_p1 <= 1'b0;
    end else begin
      if (req_fire) from_cache_p1 <= hit & cache_hit;
      if (itcm_cs)  cache_vld_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (itcm_cs) cache_addr_q <= itcm_addr;
    if ((state_q == ST_RD) && !err_p1 && !from_cache_p1) cache_data_q <= itcm_rdata;
  end
`else
  logic unused_seq;
  assign unused_seq = ifu_req_seq;
  assign itcm_cs    = req_fire & hit;
  assign rd_data    = itcm_rdata;
`endif

  assign rd_instr = err_p1 ? ERR_INSTR : rd_data;

  // Buffer reloads every RD cycle so idle outputs keep the last response.
  qpu_ift_rsp_buf #(.INSTR_W(INSTR_W)) u_rsp_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (state_q == ST_RD),
    .set_vld   ((state_q == ST_RD) & ~ifu_rsp_ready),
    .clr_vld   (buf_vld & ifu_rsp_ready),
    .din_err   (err_p1),
    .din_instr (rd_instr),
    .vld       (buf_vld),
    .err       (buf_err),
    .instr     (buf_instr)
  );

  assign ifu_rsp_instr = (state_q == ST_RD) ? rd_instr : buf_instr;
  assign ifu_rsp_err   = (state_q == ST_RD) ? err_p1   : buf_err;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_fire) state_d = ST_RD;
      ST_RD:   if (!ifu_rsp_ready) state_d = ST_HOLD;
               else state_d = req_fire ? ST_RD : ST_IDLE;
      ST_HOLD: if (ifu_rsp_ready) state_d = req_fire ? ST_RD : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Request -> response stage boundary
  always_ff @(posedge clk) begin
    if (req_fire) err_p1 <= ~hit;
  end

endmodule

// File: tb/tb_qpu_ifu_ift2itcm.sv
// Directed bench for qpu_ifu_ift2itcm: table of single fetches plus hand-written multi-cycle sequences.
module tb_qpu_ifu_ift2itcm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_req_seq;
  logic [31:0] ifu_req_pc;
  logic        ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
  logic [31:0] ifu_rsp_instr;
  logic        itcm_cs;
  logic [11:0] itcm_addr;
  logic [31:0] itcm_rdata;

  logic [31:0] mem [0:4095];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // SRAM model: outputs garbage on cycles without a read so stale pass-through is visible.
  always @(posedge clk) itcm_rdata <= itcm_cs ? mem[itcm_addr] : 32'hDEAD_BEEF;

  qpu_ifu_ift2itcm dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_req_pc    (ifu_req_pc),
    .ifu_req_seq   (ifu_req_seq),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_ready (ifu_rsp_ready),
    .ifu_rsp_instr (ifu_rsp_instr),
    .ifu_rsp_err   (ifu_rsp_err),
    .itcm_cs       (itcm_cs),
    .itcm_addr     (itcm_addr),
    .itcm_rdata    (itcm_rdata)
  );

  typedef struct {
    logic [31:0] pc;
    logic        cs;
    logic [11:0] addr;
    logic        err;
    logic [31:0] instr;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA500_0000 | i;
    vt[0] = '{32'h8000_0010, 1'b1, 12'h004, 1'b0, 32'hA500_0004};
    vt[1] = '{32'h0000_1000, 1'b0, 12'h000, 1'b1, 32'h0000_0013};
    vt[2] = '{32'h8000_0002, 1'b0, 12'h000, 1'b1, 32'h0000_0013};
    vt[3] = '{32'h8000_3FFC, 1'b1, 12'hFFF, 1'b0, 32'hA500_0FFF};
    vt[4] = '{32'h8000_4000, 1'b0, 12'h000, 1'b1, 32'h0000_0013};
    vt[5] = '{32'h7FFF_FFFC, 1'b0, 12'h000, 1'b1, 32'h0000_0013};

    rst_n = 1'b0; ifu_req_valid = 1'b0; ifu_req_pc = '0; ifu_req_seq = 1'b0; ifu_rsp_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1; #1;
    chk("rst_rsp_valid", 32'(ifu_rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(ifu_req_ready), 32'd1);
    chk("rst_cs", 32'(itcm_cs), 32'd0);
    chk("rst_instr", ifu_rsp_instr, 32'h0);
    chk("rst_err", 32'(ifu_rsp_err), 32'd0);

    for (int i = 0; i < 6; i++) begin
      tick();
      ifu_req_valid = 1'b1; ifu_req_pc = vt[i].pc; ifu_rsp_ready = 1'b1; #1;
      chk("vec_req_ready", 32'(ifu_req_ready), 32'd1);
      chk("vec_cs", 32'(itcm_cs), 32'(vt[i].cs));
      if (vt[i].cs) chk("vec_addr", 32'(itcm_addr), 32'(vt[i].addr));
      tick();
      ifu_req_valid = 1'b0; #1;
      chk("vec_rsp_valid", 32'(ifu_rsp_valid), 32'd1);
      chk("vec_instr", ifu_rsp_instr, vt[i].instr);
      chk("vec_err", 32'(ifu_rsp_err), 32'(vt[i].err));
      tick();
      chk("vec_idle_valid", 32'(ifu_rsp_valid), 32'd0);
      chk("vec_idle_ready", 32'(ifu_req_ready), 32'd1);
    end

    // Back-to-back streaming, no bubbles
    tick();
    ifu_req_valid = 1'b1; ifu_req_pc = 32'h8000_0000; #1;
    chk("b2b_cs0", 32'(itcm_cs), 32'd1);
    chk("b2b_addr0", 32'(itcm_addr), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k < 3) ifu_req_pc = 32'h8000_0000 + 32'(k * 4);
      else       ifu_req_valid = 1'b0;
      #1;
      chk("b2b_rsp_valid", 32'(ifu_rsp_valid), 32'd1);
      chk("b2b_instr", ifu_rsp_instr, 32'hA500_0000 | 32'(k - 1));
      if (k < 3) begin
        chk("b2b_req_ready", 32'(ifu_req_ready), 32'd1);
        chk("b2b_cs", 32'(itcm_cs), 32'd1);
        chk("b2b_addr", 32'(itcm_addr), 32'(k));
      end
    end
    tick();
    chk("b2b_end_valid", 32'(ifu_rsp_valid), 32'd0);

    // Back-pressure: three stalled cycles then handshake with a new request
    tick();
    ifu_req_valid = 1'b1; ifu_req_pc = 32'h8000_0020; #1;
    chk("hold_cs", 32'(itcm_cs), 32'd1);
    chk("hold_addr", 32'(itcm_addr), 32'd8);
    tick();
    ifu_req_valid = 1'b0; ifu_rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_valid", 32'(ifu_rsp_valid), 32'd1);
      chk("hold_instr", ifu_rsp_instr, 32'hA500_0008);
      chk("hold_req_ready", 32'(ifu_req_ready), 32'd0);
      mem[8] = 32'h1234_5678;
      tick();
    end
    ifu_rsp_ready = 1'b1; ifu_req_valid = 1'b1; ifu_req_pc = 32'h8000_000C; #1;
    chk("hold_4th_valid", 32'(ifu_rsp_valid), 32'd1);
    chk("hold_4th_instr", ifu_rsp_instr, 32'hA500_0008);
    chk("hold_4th_req_ready", 32'(ifu_req_ready), 32'd1);
    chk("hold_4th_cs", 32'(itcm_cs), 32'd1);
    tick();
    ifu_req_valid = 1'b0; #1;
    chk("hold_next_instr", ifu_rsp_instr, 32'hA500_0003);
    tick();
    chk("hold_done_valid", 32'(ifu_rsp_valid), 32'd0);
    mem[8] = 32'hA500_0008;

    // Reset while holding a response
    tick();
    ifu_req_valid = 1'b1; ifu_req_pc = 32'h8000_0010; #1;
    tick();
    ifu_req_valid = 1'b0; ifu_rsp_ready = 1'b0;
    tick();
    chk("rsthold_pre_valid", 32'(ifu_rsp_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; #1;
    chk("rsthold_valid", 32'(ifu_rsp_valid), 32'd0);
    chk("rsthold_req_ready", 32'(ifu_req_ready), 32'd1);
    chk("rsthold_instr", ifu_rsp_instr, 32'h0);
    ifu_rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rsthold_no_stale", 32'(ifu_rsp_valid), 32'd0);
    end

    // Sequential re-fetch of the same word
    tick();
    ifu_req_valid = 1'b1; ifu_req_pc = 32'h8000_0040; ifu_req_seq = 1'b0; #1;
    chk("seq_cs0", 32'(itcm_cs), 32'd1);
    chk("seq_addr0", 32'(itcm_addr), 32'h10);
    tick();
    ifu_req_seq = 1'b1; #1;
`ifdef QPU_IFT2ITCM_SEQ_REUSE_EN
    chk("seq_cs1", 32'(itcm_cs), 32'd0);
`else
    chk("seq_cs1", 32'(itcm_cs), 32'd1);
`endif
    chk("seq_rsp0", ifu_rsp_instr, 32'hA500_0010);
    tick();
    ifu_req_valid = 1'b0; ifu_req_seq = 1'b0; #1;
    chk("seq_rsp1_valid", 32'(ifu_rsp_valid), 32'd1);
    chk("seq_rsp1", ifu_rsp_instr, 32'hA500_0010);
    chk("seq_rsp1_err", 32'(ifu_rsp_err), 32'd0);
    tick();
    chk("seq_end_valid", 32'(ifu_rsp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
